// File: rtl/imem_prefetch_buffer_if.sv
// Bus bundle between the prefetch buffer, the instruction memory and the core
// fetch/decode boundary. The master side is the prefetch buffer itself.
interface imem_prefetch_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // IMEM side
  logic [DATA_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_instr;

  // Core side
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [DATA_WIDTH-1:0] out_pc;
  logic                  out_ready;
  logic                  redirect;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic [CNT_W-1:0]      fill_level;

  modport master (
    output imem_addr,
    input  imem_instr,
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready,
    input  redirect,
    input  redirect_pc,
    output fill_level
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready,
    output redirect,
    output redirect_pc,
    input  fill_level
  );
endinterface

// File: rtl/imem_prefetch_buffer.sv
// Instruction prefetch buffer: owns the fetch PC, captures {pc, instr} pairs
// from a combinational IMEM into a small FIFO and hands them to the core over
// a valid/ready handshake. A redirect flushes the FIFO and restarts fetch.
module imem_prefetch_buffer #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = {DATA_WIDTH{1'b0}},
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  imem_prefetch_buffer_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Occupancy view: FULL means a push can only ride along with a pop
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } fill_state_e;

  // Word-alignment mask applied to redirect targets
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

  logic [DATA_WIDTH-1:0] fpc_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [DATA_WIDTH-1:0] pc_mem_r    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem_r [DEPTH];

  fill_state_e           state_s;
  logic                  out_valid_s;
  logic                  pop_s;
  logic                  push_s;
  logic [DATA_WIDTH-1:0] fpc_nxt_s;
  logic [PTR_W-1:0]      rd_ptr_nxt_s;
  logic [PTR_W-1:0]      wr_ptr_nxt_s;
  logic [CNT_W-1:0]      count_nxt_s;

  // Derive the conceptual FILL/FULL state from the entry count
  always_comb begin
    if (count_r == CNT_W'(DEPTH)) begin
      state_s = ST_FULL;
    end else begin
      state_s = ST_FILL;
    end
  end

  // Handshake decode: pop when the head is accepted, push unless redirecting or blocked
  always_comb begin
    out_valid_s = (count_r != {CNT_W{1'b0}});
    pop_s       = out_valid_s & bus.out_ready;
    case (state_s)
      ST_FILL: push_s = ~bus.redirect;
      ST_FULL: push_s = ~bus.redirect & pop_s;
      default: push_s = 1'b0;
    endcase
  end

  // Next-state for fetch PC, pointers and count; redirect overrides push and pop
  always_comb begin
    fpc_nxt_s    = fpc_r;
    rd_ptr_nxt_s = rd_ptr_r;
    wr_ptr_nxt_s = wr_ptr_r;
    count_nxt_s  = count_r;
    if (bus.redirect) begin
      fpc_nxt_s    = bus.redirect_pc & ALIGN_MASK;
      rd_ptr_nxt_s = {PTR_W{1'b0}};
      wr_ptr_nxt_s = {PTR_W{1'b0}};
      count_nxt_s  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1'b1);
        fpc_nxt_s    = fpc_r + DATA_WIDTH'(32'd4);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1'b1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      if (push_s && !pop_s) begin
        count_nxt_s = count_r + CNT_W'(1'b1);
      end else if (!push_s && pop_s) begin
        count_nxt_s = count_r - CNT_W'(1'b1);
      end else begin
        count_nxt_s = count_r;
      end
    end
  end

  // Control state register: fetch PC, pointers and count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_r    <= RESET_PC;
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      fpc_r    <= fpc_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      count_r  <= count_nxt_s;
    end
  end

  // Entry storage: capture the fetched word with its PC at the write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]    <= {DATA_WIDTH{1'b0}};
        instr_mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (push_s) begin
      pc_mem_r[wr_ptr_r]    <= fpc_r;
      instr_mem_r[wr_ptr_r] <= bus.imem_instr;
    end
  end

  // Output view of the head entry; an empty FIFO presents a NOP at PC 0
  always_comb begin
    bus.imem_addr  = fpc_r;
    bus.out_valid  = out_valid_s;
    bus.fill_level = count_r;
    if (out_valid_s) begin
      bus.out_instr = instr_mem_r[rd_ptr_r];
      bus.out_pc    = pc_mem_r[rd_ptr_r];
    end else begin
      bus.out_instr = NOP_INSTR;
      bus.out_pc    = {DATA_WIDTH{1'b0}};
    end
  end
endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// Self-checking bench for imem_prefetch_buffer. IMEM word k holds k+1.
// A scoreboard queue holds the expected FIFO contents: entries are pushed when
// the stimulus implies a fetch, and compared/popped when the core accepts them.
module tb_imem_prefetch_buffer;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  ent_t        sb[$];
  logic [31:0] m_fpc;

  imem_prefetch_buffer_if #(.DATA_WIDTH(32), .DEPTH(DEPTH)) bus ();

  imem_prefetch_buffer #(
    .DATA_WIDTH(32),
    .DEPTH     (DEPTH),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  // Combinational IMEM: word k holds k+1
  assign bus.imem_instr = (bus.imem_addr >> 2) + 32'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, update the scoreboard model, advance to the next negedge
  task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc);
    logic pop;
    bus.out_ready   = rdy;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    pop = (sb.size() != 0) && rdy;
    if (rd) begin
      sb.delete();
      m_fpc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (pop) sb.delete(0);
      if (sb.size() < DEPTH) begin
        sb.push_back('{pc: m_fpc, instr: (m_fpc >> 2) + 32'd1});
        m_fpc = m_fpc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    sb.delete();
    m_fpc = 32'h0;
  endtask

  task automatic do_reset();
    bus.out_ready = 1'b0;
    bus.redirect  = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #7;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.out_instr !== NOP) begin n_fail++; $display("FAIL rst_instr: got %h exp %h", bus.out_instr, NOP); end
    n_checks++; if (bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h exp 0", bus.out_pc); end
    n_checks++; if (bus.fill_level !== 3'd0) begin n_fail++; $display("FAIL rst_fill: got %0d exp 0", bus.fill_level); end
    n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h exp 0", bus.imem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rel_valid: got %b exp 0", bus.out_valid); end
    step(1'b1, 1'b0, 32'h0);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b exp 1", bus.out_valid); end
    n_checks++; if (bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL first_pc: got %h exp 0", bus.out_pc); end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 32'h0);
      n_checks++; if (bus.out_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h exp %h", i, bus.out_pc, 32'(4 * i)); end
      n_checks++; if (bus.out_instr !== 32'(i + 1)) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h exp %h", i, bus.out_instr, 32'(i + 1)); end
      n_checks++; if (bus.fill_level !== 3'd1) begin n_fail++; $display("FAIL stream_fill[%0d]: got %0d exp 1", i, bus.fill_level); end
    end
  endtask

  task automatic test_stall();
    int lvl;
    do_reset();
    for (int j = 1; j <= 6; j++) begin
      step(1'b0, 1'b0, 32'h0);
      lvl = (j < DEPTH) ? j : DEPTH;
      n_checks++; if (bus.fill_level !== 3'(lvl)) begin n_fail++; $display("FAIL stall_fill[%0d]: got %0d exp %0d", j, bus.fill_level, lvl); end
      n_checks++; if (bus.imem_addr !== 32'(4 * lvl)) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h exp %h", j, bus.imem_addr, 32'(4 * lvl)); end
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (bus.out_pc !== 32'(4 * k)) begin n_fail++; $display("FAIL drain_pc[%0d]: got %h exp %h", k, bus.out_pc, 32'(4 * k)); end
      n_checks++; if (sb.size() == 0 || bus.out_instr !== sb[0].instr) begin n_fail++; $display("FAIL drain_sb[%0d]: got %h exp %h", k, bus.out_instr, (sb.size() != 0) ? sb[0].instr : 32'hx); end
      step(1'b1, 1'b0, 32'h0);
    end
    n_checks++; if (bus.fill_level !== 3'd4) begin n_fail++; $display("FAIL drain_fill: got %0d exp 4", bus.fill_level); end
  endtask

  task automatic test_redirect_full();
    step(1'b1, 1'b1, 32'h40);
    n_checks++; if (bus.fill_level !== 3'd0) begin n_fail++; $display("FAIL redir_fill: got %0d exp 0", bus.fill_level); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.out_instr !== NOP) begin n_fail++; $display("FAIL redir_instr: got %h exp %h", bus.out_instr, NOP); end
    n_checks++; if (bus.imem_addr !== 32'h40) begin n_fail++; $display("FAIL redir_addr: got %h exp 40", bus.imem_addr); end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 32'h0);
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(32'h40 + 4 * k)) begin n_fail++; $display("FAIL redir_pc[%0d]: got %b/%h exp 1/%h", k, bus.out_valid, bus.out_pc, 32'(32'h40 + 4 * k)); end
      n_checks++; if (bus.out_instr !== 32'(17 + k)) begin n_fail++; $display("FAIL redir_seq_instr[%0d]: got %h exp %h", k, bus.out_instr, 32'(17 + k)); end
    end
  endtask

  task automatic test_redirect_unaligned();
    step(1'b1, 1'b1, 32'h4E);
    n_checks++; if (bus.imem_addr !== 32'h4C) begin n_fail++; $display("FAIL unal_addr: got %h exp 4c", bus.imem_addr); end
    step(1'b1, 1'b0, 32'h0);
    n_checks++; if (bus.out_pc !== 32'h4C) begin n_fail++; $display("FAIL unal_pc: got %h exp 4c", bus.out_pc); end
    n_checks++; if (bus.out_instr !== 32'd20) begin n_fail++; $display("FAIL unal_instr: got %h exp 14", bus.out_instr); end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b1, 32'h100);
    step(1'b1, 1'b1, 32'h200);
    step(1'b1, 1'b1, 32'h300);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid: got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.imem_addr !== 32'h300) begin n_fail++; $display("FAIL b2b_addr: got %h exp 300", bus.imem_addr); end
    step(1'b1, 1'b0, 32'h0);
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h300) begin n_fail++; $display("FAIL b2b_pc: got %b/%h exp 1/300", bus.out_valid, bus.out_pc); end
    n_checks++; if (bus.fill_level !== 3'd1) begin n_fail++; $display("FAIL b2b_fill: got %0d exp 1", bus.fill_level); end
    step(1'b1, 1'b0, 32'h0);
    n_checks++; if (bus.out_pc !== 32'h304) begin n_fail++; $display("FAIL b2b_next: got %h exp 304", bus.out_pc); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 32'h0);
    n_checks++; if (bus.fill_level !== 3'd3) begin n_fail++; $display("FAIL mid_pre_fill: got %0d exp 3", bus.fill_level); end
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_addr: got %h exp 0", bus.imem_addr); end
    n_checks++; if (bus.fill_level !== 3'd0) begin n_fail++; $display("FAIL mid_fill: got %0d exp 0", bus.fill_level); end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 32'h0);
    n_checks++; if (bus.out_pc !== 32'h0 || bus.out_instr !== 32'd1) begin n_fail++; $display("FAIL mid_restart: got %h/%h exp 0/1", bus.out_pc, bus.out_instr); end
    step(1'b1, 1'b0, 32'h0);
    n_checks++; if (bus.out_pc !== 32'h4) begin n_fail++; $display("FAIL mid_restart2: got %h exp 4", bus.out_pc); end
  endtask

  task automatic test_random();
    logic        rdy;
    logic        rd;
    logic [31:0] rpc;
    for (int c = 0; c < 300; c++) begin
      n_checks++; if (bus.out_valid !== (sb.size() != 0)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b exp %b", c, bus.out_valid, sb.size() != 0); end
      n_checks++; if (bus.fill_level !== 3'(sb.size())) begin n_fail++; $display("FAIL rnd_fill[%0d]: got %0d exp %0d", c, bus.fill_level, sb.size()); end
      n_checks++; if (bus.imem_addr !== m_fpc) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h exp %h", c, bus.imem_addr, m_fpc); end
      if (sb.size() != 0) begin
        n_checks++; if (bus.out_pc !== sb[0].pc || bus.out_instr !== sb[0].instr) begin n_fail++; $display("FAIL rnd_head[%0d]: got %h/%h exp %h/%h", c, bus.out_pc, bus.out_instr, sb[0].pc, sb[0].instr); end
      end else begin
        n_checks++; if (bus.out_pc !== 32'h0 || bus.out_instr !== NOP) begin n_fail++; $display("FAIL rnd_empty[%0d]: got %h/%h exp 0/%h", c, bus.out_pc, bus.out_instr, NOP); end
      end
      rdy = ($urandom_range(0, 2) != 0);
      rd  = ($urandom_range(0, 11) == 0);
      rpc = $urandom();
      step(rdy, rd, rpc);
    end
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    bus.out_ready   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    m_fpc           = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_redirect_unaligned();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_prefetch_buffer.md
# imem_prefetch_buffer

Instruction prefetch stage between the word-indexed instruction memory (IMEM) and the fetch/decode boundary of the pipelined RISC-V core. It owns the fetch PC and drives the IMEM byte address. Each fetched instruction is captured with its PC into a small FIFO, and the FIFO is drained by the core through a valid/ready handshake. A branch/jump redirect from the core flushes the FIFO and restarts fetch at the target, so IMEM latency and core stalls are decoupled from the hazard logic.

## Interface
- DATA_WIDTH, 32, instruction and PC width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, fetch PC after reset; must be word-aligned.
- NOP_INSTR, 32'h0000_0013, value on out_instr while the FIFO is empty (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  DATA_WIDTH  byte address to IMEM; the top level divides it by 4.
- imem_instr  in  DATA_WIDTH  IMEM read data; combinational from imem_addr in the same cycle.
- out_valid  out  1  head entry is valid.
- out_instr  out  DATA_WIDTH  head instruction; NOP_INSTR when empty.
- out_pc  out  DATA_WIDTH  PC of the head instruction; 0 when empty.
- out_ready  in  1  core accepts the head this cycle; low means stall.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  DATA_WIDTH  target of the redirect; bits [1:0] ignored and forced to 0.
- fill_level  out  $clog2(DEPTH)+1  current entry count, 0..DEPTH.

## Operation
- State: fetch PC `fpc`, read pointer, write pointer, count, DEPTH entries of {pc, instr}.
- imem_addr = fpc, combinational from the register.
- pop = out_valid & out_ready.
- push = !redirect & (count < DEPTH | pop).
- On push: the entry at the write pointer takes {fpc, imem_instr}, the write pointer increments and fpc <= fpc + 4.
- Simultaneous push and pop is allowed when full. Count is unchanged in that case and both pointers advance.
- Pointers wrap modulo DEPTH. fpc wraps modulo 2^DATA_WIDTH with no error flag.
- Redirect has priority over push and pop in the same cycle:
  - pointers and count go to 0;
  - fpc <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
  - the pop that cycle is discarded, and the core must treat its head instruction as squashed.
- out_valid = (count != 0). out_instr and out_pc read the entry at the read pointer, or NOP_INSTR/0 when empty.
- fill_level = count.
- Two conceptual states:
  - FILL: count < DEPTH, so a push happens every non-redirect cycle.
  - FULL: count == DEPTH, so a push happens only together with a pop.
  - The state is derived from count; there is no separate state register.

## Timing
- Reset (async assert, sync release at the next edge):
  - fpc = RESET_PC; pointers, count and fill_level = 0; entry storage = 0;
  - out_valid = 0, out_instr = NOP_INSTR, out_pc = 0, imem_addr = RESET_PC.
- First edge after rst_n rises: the first push happens. out_valid = 1 with out_pc = RESET_PC one cycle after release.
- Throughput: one instruction per cycle sustained while out_ready = 1. Fetch-to-output latency is 1 cycle.
- Stall: with out_ready held low, the FIFO fills to DEPTH after DEPTH edges and fpc then freezes. After out_ready rises, the head is consumed the same cycle and the refill push happens on that same edge.
- Redirect asserted in cycle N:
  - out_valid = 0 in cycle N+1, with imem_addr = target.
  - out_valid = 1 with out_pc = target in cycle N+2. The redirect penalty is 2 cycles.
- Back-to-back redirects: the last one wins. No push happens on any redirect cycle.
- Reset mid-stream: all entries are lost immediately and the block behaves exactly as after power-up reset.

## Test plan
- Reset release, out_ready = 1, IMEM word k = k+1: out_pc sequence 0,4,8,… on consecutive cycles; out_instr = 1,2,3,…; first valid one cycle after release.
- Hold out_ready = 0 for 6 cycles: fill_level climbs 1..4 and saturates; imem_addr freezes at 16. Release out_ready: out_pc continues 0,4,8,… with no gap or duplicate.
- Redirect with redirect_pc = 32'h40 while full and out_ready = 1:
  - fill_level = 0 next cycle;
  - out_instr = NOP_INSTR, out_valid = 0 for 1 cycle;
  - then out_pc = 0x40, 0x44, ….
- Redirect with redirect_pc = 32'h4E: fetch resumes at 0x4C.
- Redirects on 3 consecutive cycles to 0x100, 0x200, 0x300: only 0x300 appears on out_pc, 2 cycles after the last redirect.
- Assert rst_n = 0 asynchronously mid-cycle while 3 entries are queued: out_valid drops immediately and imem_addr = RESET_PC. After release, the sequence restarts at RESET_PC.
